// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-port arbiter sequencing ISSUE -> RESP accesses onto a single
//            single-port synchronous memory with a 1-cycle registered read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter bit FIXED_PRIORITY = 1'b0,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    input  logic [3:0]            m0_wmask,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [31:0]           m0_rdata,
    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    input  logic [3:0]            m1_wmask,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [31:0]           m1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wmask,
    input  logic [31:0]           mem_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_sel;
    logic                    r_last;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [31:0]             r_wdata;
    logic [3:0]              r_wmask;
    logic                    w_gnt0;
    logic                    w_gnt1;

    // Grants are only possible outside ISSUE; resetn gating keeps gnt low while in reset.
    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = r_state;
        if (resetn && (r_state != S_ISSUE)) begin
            if (m0_req && m1_req) begin
                if (FIXED_PRIORITY || r_last) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else begin
                w_gnt0 = m0_req;
                w_gnt1 = m1_req;
            end
        end
        case (r_state)
            S_IDLE:  if (w_gnt0 || w_gnt1) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = (w_gnt0 || w_gnt1) ? S_ISSUE : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_sel   <= 1'b0;
            r_last  <= 1'b1;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_wmask <= 4'h0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt0 || w_gnt1) begin
                r_sel   <= w_gnt1;
                r_last  <= w_gnt1;
                r_addr  <= w_gnt1 ? m1_addr  : m0_addr;
                r_wdata <= w_gnt1 ? m1_wdata : m0_wdata;
                r_wmask <= w_gnt1 ? m1_wmask : m0_wmask;
            end
        end
    end

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign m0_rvalid = (r_state == S_RESP) && !r_sel;
    assign m1_rvalid = (r_state == S_RESP) &&  r_sel;
    assign m0_rdata  = m0_rvalid ? mem_rdata : 32'h0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : 32'h0;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    // Strobes exist only in ISSUE, so an async reset there aborts the write at once.
    assign mem_wmask = (r_state == S_ISSUE) ? r_wmask : 4'h0;
    assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter with a behavioural memory and
//            a transaction-level reference model (shadow memory + arbitration).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_addr = 32'h0, m1_addr = 32'h0;
    logic [31:0] m0_wdata = 32'h0, m1_wdata = 32'h0;
    logic [3:0]  m0_wmask = 4'h0, m1_wmask = 4'h0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    logic        f_m0_gnt, f_m1_gnt, f_m0_rvalid, f_m1_rvalid, f_busy;
    logic [31:0] f_m0_rdata, f_m1_rdata, f_mem_addr, f_mem_wdata;
    logic [3:0]  f_mem_wmask;
    logic [31:0] f_mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.FIXED_PRIORITY(1'b0), .ADDR_WIDTH(32)) u_dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.FIXED_PRIORITY(1'b1), .ADDR_WIDTH(32)) u_fix (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
        .m0_gnt(f_m0_gnt), .m0_rvalid(f_m0_rvalid), .m0_rdata(f_m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
        .m1_gnt(f_m1_gnt), .m1_rvalid(f_m1_rvalid), .m1_rdata(f_m1_rdata),
        .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_wmask(f_mem_wmask),
        .mem_rdata(f_mem_rdata), .busy(f_busy)
    );

    function automatic logic [31:0] init_word(int i);
        if (i == 1)  return 32'h00108093;
        if (i == 12) return 32'h11111111;
        return 32'hA5000000 ^ (i * 32'h01010101);
    endfunction

    // Behavioural single-port memory: registered read, byte-masked write.
    logic [31:0] mem [0:63];
    bit          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            mem_init  <= 1'b1;
            mem_rdata <= 32'h0;
        end else begin
            mem_rdata <= mem[mem_addr[7:2]];
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Reference model: an access granted at cycle t occupies the memory at t+1
    // and completes at t+2; a new grant is possible whenever none happened at t-1.
    typedef struct {
        bit          v;
        bit          port;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } acc_t;

    acc_t        st1, st2, nw;
    int          last_p = 1;
    logic [31:0] shadow [0:63];
    bit          eg0, eg1;
    logic [31:0] exp_rd0, exp_rd1;

    always @(negedge clk) begin
        checks++;
        if (!resetn) begin
            st1.v = 1'b0; st2.v = 1'b0; last_p = 1;
            if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy} !== 5'b0 || mem_wmask !== 4'h0
                || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
                errors++;
                $display("FAIL in_reset_outputs: gnt=%b%b rv=%b%b busy=%b wmask=%h, required all 0",
                         m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy, mem_wmask);
            end
        end else begin
            eg0 = 1'b0; eg1 = 1'b0;
            if (!st1.v) begin
                if (m0_req && m1_req) begin
                    eg0 = (last_p == 1); eg1 = (last_p == 0);
                end else begin
                    eg0 = m0_req; eg1 = m1_req;
                end
            end
            if (m0_gnt !== eg0 || m1_gnt !== eg1) begin
                errors++;
                $display("FAIL sb_gnt: got %b%b required %b%b at %0t", m0_gnt, m1_gnt, eg0, eg1, $time);
            end
            exp_rd0 = 32'h0; exp_rd1 = 32'h0;
            if (st2.v) begin
                if (st2.wmask == 4'h0) begin
                    if (st2.port) exp_rd1 = shadow[st2.addr[7:2]];
                    else          exp_rd0 = shadow[st2.addr[7:2]];
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (st2.wmask[b]) shadow[st2.addr[7:2]][8*b +: 8] = st2.wdata[8*b +: 8];
                end
            end
            checks++;
            if (m0_rvalid !== (st2.v && !st2.port) || m1_rvalid !== (st2.v && st2.port)) begin
                errors++;
                $display("FAIL sb_rvalid: got %b%b at %0t", m0_rvalid, m1_rvalid, $time);
            end
            if (!(st2.v && st2.wmask != 4'h0)) begin
                checks++;
                if (m0_rdata !== exp_rd0 || m1_rdata !== exp_rd1) begin
                    errors++;
                    $display("FAIL sb_rdata: got %h/%h required %h/%h at %0t",
                             m0_rdata, m1_rdata, exp_rd0, exp_rd1, $time);
                end
            end
            checks++;
            if (busy !== (st1.v || st2.v) || mem_wmask !== (st1.v ? st1.wmask : 4'h0)
                || (st1.v && (mem_addr !== st1.addr || mem_wdata !== st1.wdata))) begin
                errors++;
                $display("FAIL sb_memside: busy=%b wmask=%h addr=%h at %0t", busy, mem_wmask, mem_addr, $time);
            end
            st2 = st1;
            nw.v = eg0 || eg1;
            nw.port = eg1;
            nw.addr  = eg1 ? m1_addr  : m0_addr;
            nw.wdata = eg1 ? m1_wdata : m0_wdata;
            nw.wmask = eg1 ? m1_wmask : m0_wmask;
            st1 = nw;
            if (nw.v) last_p = eg1 ? 1 : 0;
        end
    end

    task automatic drive(input bit p, input bit req, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        if (p) begin m1_req = req; m1_addr = a; m1_wdata = d; m1_wmask = m; end
        else   begin m0_req = req; m0_addr = a; m0_wdata = d; m0_wmask = m; end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wmask !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b addr=%h wdata=%h wmask=%h, required 0", busy, mem_addr, mem_wdata, mem_wmask);
        end
        @(posedge clk); #1 resetn = 1'b1;
    endtask

    task automatic test_read();
        @(posedge clk); #1 drive(0, 1, 32'h4, 32'h0, 4'h0);
        @(negedge clk); checks++;
        if (m0_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt0: got %b required 1", m0_gnt); end
        @(posedge clk); #1 drive(0, 0, 32'h0, 32'h0, 4'h0);
        @(negedge clk); checks++;
        if (mem_addr !== 32'h4 || busy !== 1'b1) begin
            errors++; $display("FAIL rd_issue: addr=%h busy=%b required 4/1", mem_addr, busy);
        end
        @(negedge clk); checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h00108093 || busy !== 1'b1) begin
            errors++; $display("FAIL rd_resp: rv=%b rdata=%h required 1/00108093", m0_rvalid, m0_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_write_readback();
        @(posedge clk); #1 drive(1, 1, 32'h20, 32'hDEADBEEF, 4'hF);
        @(negedge clk); checks++;
        if (m1_gnt !== 1'b1 || mem_wmask !== 4'h0) begin
            errors++; $display("FAIL wr_gnt1: gnt=%b wmask=%h required 1/0", m1_gnt, mem_wmask);
        end
        @(posedge clk); #1 drive(1, 0, 32'h0, 32'h0, 4'h0);
        @(negedge clk); checks++;
        if (mem_wmask !== 4'hF || mem_addr !== 32'h20 || mem_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_issue: wmask=%h addr=%h wdata=%h", mem_wmask, mem_addr, mem_wdata);
        end
        @(posedge clk); #1 drive(1, 1, 32'h20, 32'h0, 4'h0);
        @(negedge clk); checks++;
        if (m1_rvalid !== 1'b1 || mem_wmask !== 4'h0 || m1_gnt !== 1'b1) begin
            errors++; $display("FAIL wr_resp: rv=%b wmask=%h gnt=%b required 1/0/1", m1_rvalid, mem_wmask, m1_gnt);
        end
        @(posedge clk); #1 drive(1, 0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        @(negedge clk); checks++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_readback: rv=%b rdata=%h required 1/deadbeef", m1_rvalid, m1_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        int prev_p = -1, prev_c = -1, fix0 = 0;
        @(posedge clk); #1 drive(0, 1, 32'h8, 32'h0, 4'h0); drive(1, 1, 32'hC, 32'h0, 4'h0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (m0_gnt || m1_gnt) begin
                checks++;
                if ((prev_c >= 0 && (c - prev_c != 2 || (m1_gnt ? 1 : 0) == prev_p))
                    || (prev_c < 0 && (c != 0 || !m0_gnt))) begin
                    errors++; $display("FAIL rr_alternate: cycle %0d port %0d prev %0d@%0d", c, m1_gnt, prev_p, prev_c);
                end
                prev_p = m1_gnt ? 1 : 0; prev_c = c;
            end
            checks++;
            if (f_m1_gnt !== 1'b0) begin errors++; $display("FAIL fixed_prio: m1 granted while m0 requests"); end
            if (f_m0_gnt) fix0++;
        end
        checks++;
        if (prev_c != 6 || fix0 != 4) begin
            errors++; $display("FAIL rr_count: last grant %0d required 6, fixed m0 grants %0d required 4", prev_c, fix0);
        end
        @(posedge clk); #1 drive(0, 0, 32'h0, 32'h0, 4'h0); drive(1, 0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_issue();
        @(posedge clk); #1 drive(1, 1, 32'h30, 32'hCAFEF00D, 4'hF);
        @(negedge clk); checks++;
        if (m1_gnt !== 1'b1) begin errors++; $display("FAIL rst_gnt: got %b required 1", m1_gnt); end
        @(posedge clk); #1 drive(1, 0, 32'h0, 32'h0, 4'h0);
        #1 resetn = 1'b0;
        #1 checks++;
        if (mem_wmask !== 4'h0 || busy !== 1'b0 || m1_rvalid !== 1'b0) begin
            errors++; $display("FAIL rst_immediate: wmask=%h busy=%b rv=%b required 0", mem_wmask, busy, m1_rvalid);
        end
        repeat (2) @(negedge clk);
        @(posedge clk); #1 resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); checks++;
            if (m0_rvalid || m1_rvalid) begin errors++; $display("FAIL rst_stale_rvalid: rv=%b%b", m0_rvalid, m1_rvalid); end
        end
        @(posedge clk); #1 drive(0, 1, 32'h30, 32'h0, 4'h0);
        @(posedge clk); #1 drive(0, 0, 32'h0, 32'h0, 4'h0);
        @(negedge clk); @(negedge clk); checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h11111111) begin
            errors++; $display("FAIL rst_no_write: rv=%b rdata=%h required 1/11111111", m0_rvalid, m0_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1 drive(0, 1, 32'h10, 32'h0, 4'h0);
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk); checks++;
            if (m0_gnt !== (c % 2 == 0 && c <= 6) || m0_rvalid !== (c % 2 == 0 && c >= 2)
                || (c >= 1 && busy !== 1'b1)) begin
                errors++; $display("FAIL b2b cycle %0d: gnt=%b rv=%b busy=%b", c, m0_gnt, m0_rvalid, busy);
            end
            if (c == 6) begin @(posedge clk); #1 drive(0, 0, 32'h0, 32'h0, 4'h0); end
        end
        @(negedge clk);
    endtask

    task automatic test_idle();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); checks++;
            if (busy || mem_wmask != 4'h0 || m0_gnt || m1_gnt || m0_rvalid || m1_rvalid) begin
                errors++; $display("FAIL idle cycle %0d: busy=%b wmask=%h gnt=%b%b rv=%b%b",
                                   c, busy, mem_wmask, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid);
            end
        end
    endtask

    task automatic test_random();
        int ng = 0, nr = 0;
        bit g0, g1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            g0 = m0_gnt; g1 = m1_gnt;
            ng += int'(g0) + int'(g1);
            nr += int'(m0_rvalid) + int'(m1_rvalid);
            @(posedge clk); #1;
            if (!m0_req || g0)
                drive(0, ($urandom % 3) != 0, $urandom_range(0, 255), $urandom,
                      ($urandom % 2) ? 4'($urandom) : 4'h0);
            if (!m1_req || g1)
                drive(1, ($urandom % 3) != 0, $urandom_range(0, 255), $urandom,
                      ($urandom % 2) ? 4'($urandom) : 4'h0);
        end
        drive(0, 0, 32'h0, 32'h0, 4'h0); drive(1, 0, 32'h0, 32'h0, 4'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ng += int'(m0_gnt) + int'(m1_gnt);
            nr += int'(m0_rvalid) + int'(m1_rvalid);
        end
        checks++;
        if (ng != nr || ng < 50) begin
            errors++; $display("FAIL rand_completion: grants=%0d rvalids=%0d", ng, nr);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
        test_reset();
        test_read();
        test_write_readback();
        test_contention();
        test_reset_mid_issue();
        test_back_to_back();
        test_idle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
